// File: rtl/mem_arb_pkg.sv
// Shared types for the byte-serial RAM arbiter: owner/state encodings,
// access length codes and the load sign/zero extension helper.
package mem_arb_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2,
        OWN_ST   = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_LAST = 2'd2
    } state_e;

    // Index of the final byte; unsupported lengths behave as a full word.
    function automatic logic [1:0] last_idx(input logic [2:0] len);
        case (len)
            LEN_B:   return 2'd0;
            LEN_H:   return 2'd1;
            LEN_W:   return 2'd3;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] extend_word(input logic [DATA_W-1:0] w,
                                                      input logic [1:0]        last,
                                                      input logic              sgn);
        case (last)
            2'd0:    return {{24{sgn & w[7]}}, w[7:0]};
            2'd1:    return {{16{sgn & w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational requester selection (LD > ST > IF) for the RAM arbiter.
// With MEM_ARB_AGE_EN defined, a waiting fetch gains top priority after AGE_LIMIT cycles.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned AGE_LIMIT = 8
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   if_req_i,
    input  logic   if_cancel_i,
    input  logic   if_ready_i,
    input  logic   ld_req_i,
    input  logic   ld_ready_i,
    input  logic   st_req_i,
    input  logic   st_ready_i,
    input  logic   idle_i,
    input  logic   if_owner_i,
    output owner_e grant_c_o
);

    logic   if_ok;
    logic   ld_ok;
    logic   st_ok;
    logic   if_urgent;
    owner_e pick_c;

    // A requester finishing this cycle may still hold req; a cancelled fetch is ignored.
    assign if_ok = if_req_i & ~if_cancel_i & ~if_ready_i;
    assign ld_ok = ld_req_i & ~ld_ready_i;
    assign st_ok = st_req_i & ~st_ready_i;

    always_comb begin
        pick_c = OWN_NONE;
        if (if_ok && if_urgent) begin
            pick_c = OWN_IF;
        end else if (ld_ok) begin
            pick_c = OWN_LD;
        end else if (st_ok) begin
            pick_c = OWN_ST;
        end else if (if_ok) begin
            pick_c = OWN_IF;
        end
    end

    assign grant_c_o = idle_i ? pick_c : OWN_NONE;

`ifdef MEM_ARB_AGE_EN
    localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);

    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    // Saturating count of cycles a fetch waits while another requester holds the RAM.
    always_comb begin
        age_d = age_q;
        if ((idle_i && pick_c == OWN_IF) || if_cancel_i) begin
            age_d = '0;
        end else if (if_ok && !if_owner_i && age_q != {AGE_W{1'b1}}) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    assign if_urgent = (32'(age_q) >= AGE_LIMIT);
`else
    logic unused_age;
    assign unused_age = ^{clk_i, rst_i, if_owner_i, 32'(AGE_LIMIT)};
    assign if_urgent  = 1'b0;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares a byte-wide RAM port between fetch, load and store, serialising each access
// into single-byte cycles. Optional fetch aging enabled by defining MEM_ARB_AGE_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned AGE_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_cancel_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [2:0]        ld_len_i,
    input  logic              ld_signed_i,
    output logic              ld_ready_o,
    output logic [DATA_W-1:0] ld_data_o,
    input  logic              st_req_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [2:0]        st_len_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic              st_ready_o,
    output logic              ram_rw_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_w_data_o,
    input  logic [7:0]        ram_r_data_i,
    output logic [1:0]        owner_o
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            grant_c;
    logic [1:0]        k_q, k_d;
    logic [1:0]        last_q, last_d;
    logic              signed_q, signed_d;
    logic [23:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_w_data_q, ram_w_data_d;
    logic              if_ready_q, if_ready_d;
    logic              ld_ready_q, ld_ready_d;
    logic              st_ready_q, st_ready_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic [1:0]        cap_idx;
    logic [DATA_W-1:0] word_c;

    mem_arb_pick #(
        .AGE_LIMIT (AGE_LIMIT)
    ) u_pick (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_cancel_i (if_cancel_i),
        .if_ready_i  (if_ready_q),
        .ld_req_i    (ld_req_i),
        .ld_ready_i  (ld_ready_q),
        .st_req_i    (st_req_i),
        .st_ready_i  (st_ready_q),
        .idle_i      (state_q == S_IDLE),
        .if_owner_i  (owner_q == OWN_IF),
        .grant_c_o   (grant_c)
    );

    // Read data trails its address by one cycle, so XFER captures the previous byte.
    assign cap_idx = k_q - 2'd1;

    always_comb begin
        word_c = buf_q;
        word_c[{last_q, 3'b000} +: 8] = ram_r_data_i;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        k_d          = k_q;
        last_d       = last_q;
        signed_d     = signed_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        ram_rw_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_w_data_d = ram_w_data_q;
        if_ready_d   = 1'b0;
        ld_ready_d   = 1'b0;
        st_ready_d   = 1'b0;
        if_data_d    = if_data_q;
        ld_data_d    = ld_data_q;
        case (state_q)
            S_IDLE: begin
                k_d = 2'd0;
                case (grant_c)
                    OWN_IF: begin
                        ram_addr_d = if_addr_i;
                        last_d     = 2'd3;
                        signed_d   = 1'b0;
                    end
                    OWN_LD: begin
                        ram_addr_d = ld_addr_i;
                        last_d     = last_idx(ld_len_i);
                        signed_d   = ld_signed_i;
                    end
                    OWN_ST: begin
                        ram_addr_d   = st_addr_i;
                        last_d       = last_idx(st_len_i);
                        signed_d     = 1'b0;
                        wdata_d      = st_data_i[31:8];
                        ram_rw_d     = 1'b1;
                        ram_w_data_d = st_data_i[7:0];
                    end
                    default: ;
                endcase
                if (grant_c != OWN_NONE) begin
                    state_d = S_XFER;
                    owner_d = grant_c;
                end
            end
            S_XFER: begin
                if (owner_q != OWN_ST && k_q != 2'd0) begin
                    buf_d[{cap_idx, 3'b000} +: 8] = ram_r_data_i;
                end
                if (owner_q == OWN_IF && if_cancel_i) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                end else if (k_q == last_q) begin
                    if (owner_q == OWN_ST) begin
                        state_d    = S_IDLE;
                        owner_d    = OWN_NONE;
                        st_ready_d = 1'b1;
                    end else begin
                        state_d = S_LAST;
                    end
                end else begin
                    k_d        = k_q + 2'd1;
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    if (owner_q == OWN_ST) begin
                        ram_rw_d     = 1'b1;
                        ram_w_data_d = wdata_q[7:0];
                        wdata_d      = {8'h00, wdata_q[23:8]};
                    end
                end
            end
            S_LAST: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                if (owner_q == OWN_IF) begin
                    if (!if_cancel_i) begin
                        if_ready_d = 1'b1;
                        if_data_d  = word_c;
                    end
                end else begin
                    ld_ready_d = 1'b1;
                    ld_data_d  = extend_word(word_c, last_q, signed_q);
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_NONE;
            k_q          <= 2'd0;
            last_q       <= 2'd0;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            buf_q        <= '0;
            ram_rw_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_w_data_q <= '0;
            if_ready_q   <= 1'b0;
            ld_ready_q   <= 1'b0;
            st_ready_q   <= 1'b0;
            if_data_q    <= '0;
            ld_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            k_q          <= k_d;
            last_q       <= last_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            ram_rw_q     <= ram_rw_d;
            ram_addr_q   <= ram_addr_d;
            ram_w_data_q <= ram_w_data_d;
            if_ready_q   <= if_ready_d;
            ld_ready_q   <= ld_ready_d;
            st_ready_q   <= st_ready_d;
            if_data_q    <= if_data_d;
            ld_data_q    <= ld_data_d;
        end
    end

    assign if_ready_o   = if_ready_q;
    assign if_data_o    = if_data_q;
    assign ld_ready_o   = ld_ready_q;
    assign ld_data_o    = ld_data_q;
    assign st_ready_o   = st_ready_q;
    assign ram_rw_o     = ram_rw_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_w_data_o = ram_w_data_q;
    assign owner_o      = owner_q;

endmodule
